// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined RV32I/RV64I immediate generator.
// Ports: clk, rst_n, flush; in_valid/in_ready/in_instr in;
// out_valid/out_ready/out_imm/out_fmt/out_instr out; dec_cnt/ill_cnt.
// XLEN must be 32 or 64.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic [31:0]      out_instr,
    output logic [CNT_W-1:0] dec_cnt,
    output logic [CNT_W-1:0] ill_cnt
);

    localparam logic [2:0] F_R   = 3'd0;
    localparam logic [2:0] F_I   = 3'd1;
    localparam logic [2:0] F_S   = 3'd2;
    localparam logic [2:0] F_B   = 3'd3;
    localparam logic [2:0] F_U   = 3'd4;
    localparam logic [2:0] F_J   = 3'd5;
    localparam logic [2:0] F_SH  = 3'd6;
    localparam logic [2:0] F_ILL = 3'd7;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic [31:0]     instr;
    } entry_t;

    logic [6:0] opc;
    logic [2:0] f3;
    logic       s;
    logic       op_i;
    logic       op_opimm;
    logic       op_sh;
    logic       op_s;
    logic       op_b;
    logic       op_u;
    logic       op_j;
    logic       op_r;
    logic [5:0] shamt;
    entry_t     dec;

    assign opc = in_instr[6:0];
    assign f3  = in_instr[14:12];
    assign s   = in_instr[31];

    assign op_opimm = (opc == 7'b0010011);
    assign op_sh    = op_opimm && (f3 == 3'b001 || f3 == 3'b101);
    assign op_i     = (opc == 7'b0000011) || (opc == 7'b1100111)
                   || (opc == 7'b1110011) || (op_opimm && !op_sh);
    assign op_s     = (opc == 7'b0100011);
    assign op_b     = (opc == 7'b1100011);
    assign op_u     = (opc == 7'b0110111) || (opc == 7'b0010111);
    assign op_j     = (opc == 7'b1101111);
    assign op_r     = (opc == 7'b0110011);

    // RV64 shifts use a 6-bit shamt, RV32 only 5 bits
    assign shamt = (XLEN == 64) ? in_instr[25:20]
                                : {1'b0, in_instr[24:20]};

    // Fill with the sign bit, then overwrite the low field bits
    always_comb begin
        dec.instr = in_instr;
        dec.fmt   = F_ILL;
        dec.imm   = '0;
        unique case (1'b1)
            op_i: begin
                dec.fmt        = F_I;
                dec.imm        = {XLEN{s}};
                dec.imm[11:0]  = in_instr[31:20];
            end
            op_sh: begin
                dec.fmt        = F_SH;
                dec.imm[5:0]   = shamt;
            end
            op_s: begin
                dec.fmt        = F_S;
                dec.imm        = {XLEN{s}};
                dec.imm[11:0]  = {in_instr[31:25], in_instr[11:7]};
            end
            op_b: begin
                dec.fmt        = F_B;
                dec.imm        = {XLEN{s}};
                dec.imm[12:0]  = {s, in_instr[7], in_instr[30:25],
                                  in_instr[11:8], 1'b0};
            end
            op_u: begin
                dec.fmt        = F_U;
                dec.imm        = {XLEN{s}};
                dec.imm[31:0]  = {in_instr[31:12], 12'b0};
            end
            op_j: begin
                dec.fmt        = F_J;
                dec.imm        = {XLEN{s}};
                dec.imm[20:0]  = {s, in_instr[19:12], in_instr[20],
                                  in_instr[30:21], 1'b0};
            end
            op_r: begin
                dec.fmt        = F_R;
            end
            default: ;
        endcase
    end

    entry_t main_q;
    entry_t skid_q;
    logic   main_valid;
    logic   skid_valid;
    logic   acc;
    logic   drain;

    // in_ready comes straight from a flop: no path from out_ready
    assign in_ready = !skid_valid;
    assign acc      = in_valid && in_ready;
    assign drain    = main_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (drain && skid_valid) begin
            main_q     <= skid_q;
            main_valid <= 1'b1;
            skid_valid <= acc;
            if (acc) begin
                skid_q <= dec;
            end
        end else if (acc && (!main_valid || drain)) begin
            main_q     <= dec;
            main_valid <= 1'b1;
        end else if (acc) begin
            skid_q     <= dec;
            skid_valid <= 1'b1;
        end else if (drain) begin
            main_valid <= 1'b0;
        end
    end

    assign out_valid = main_valid;
    assign out_imm   = main_q.imm;
    assign out_fmt   = main_q.fmt;
    assign out_instr = main_q.instr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_cnt <= '0;
            ill_cnt <= '0;
        end else if (drain && !flush) begin
            if (dec_cnt != {CNT_W{1'b1}}) begin
                dec_cnt <= dec_cnt + CNT_W'(1);
            end
            if (main_q.fmt == F_ILL && ill_cnt != {CNT_W{1'b1}}) begin
                ill_cnt <= ill_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: scoreboard bench for imm_gen_pipe.
// Drives XLEN=32, XLEN=64 and CNT_W=2 instances in lockstep.
module tb_imm_gen_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_instr;

    logic        r32, r64, rs;
    logic        v32, v64, vs;
    logic [31:0] imm32, imms;
    logic [63:0] imm64;
    logic [2:0]  fmt32, fmt64, fmts;
    logic [31:0] ins32, ins64, inss;
    logic [15:0] dec32, ill32, dec64, ill64;
    logic [1:0]  decs, ills;

    imm_gen_pipe #(.XLEN(32), .CNT_W(16)) u32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(r32), .in_instr(in_instr),
        .out_valid(v32), .out_ready(out_ready), .out_imm(imm32),
        .out_fmt(fmt32), .out_instr(ins32),
        .dec_cnt(dec32), .ill_cnt(ill32)
    );

    imm_gen_pipe #(.XLEN(64), .CNT_W(16)) u64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(r64), .in_instr(in_instr),
        .out_valid(v64), .out_ready(out_ready), .out_imm(imm64),
        .out_fmt(fmt64), .out_instr(ins64),
        .dec_cnt(dec64), .ill_cnt(ill64)
    );

    imm_gen_pipe #(.XLEN(32), .CNT_W(2)) usat (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(rs), .in_instr(in_instr),
        .out_valid(vs), .out_ready(out_ready), .out_imm(imms),
        .out_fmt(fmts), .out_instr(inss),
        .dec_cnt(decs), .ill_cnt(ills)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] i32;
        logic [63:0] i64;
        logic [2:0]  fmt;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];
    exp_t qs[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_q();
        q32.delete();
        q64.delete();
        qs.delete();
    endtask

    task automatic send(input logic [31:0] i, input logic [31:0] e32,
                        input logic [63:0] e64, input logic [2:0] f);
        int n;
        exp_t e;
        in_valid = 1'b1;
        in_instr = i;
        n = 0;
        while (!r32 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL send_timeout instr=%h", i);
        end
        e = '{instr: i, i32: e32, i64: e64, fmt: f};
        q32.push_back(e);
        q64.push_back(e);
        qs.push_back(e);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((q32.size() != 0 || q64.size() != 0 || qs.size() != 0)
               && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout left=%0d", q32.size());
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && !flush && out_ready && v32) begin
            if (q32.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra32 instr=%h", ins32);
            end else begin
                e = q32.pop_front();
                chk("imm32", 64'(imm32), 64'(e.i32));
                chk("fmt32", 64'(fmt32), 64'(e.fmt));
                chk("instr32", 64'(ins32), 64'(e.instr));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && !flush && out_ready && v64) begin
            if (q64.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra64 instr=%h", ins64);
            end else begin
                e = q64.pop_front();
                chk("imm64", imm64, e.i64);
                chk("fmt64", 64'(fmt64), 64'(e.fmt));
                chk("instr64", 64'(ins64), 64'(e.instr));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && !flush && out_ready && vs) begin
            if (qs.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extrasat instr=%h", inss);
            end else begin
                e = qs.pop_front();
                chk("immsat", 64'(imms), 64'(e.i32));
                chk("fmtsat", 64'(fmts), 64'(e.fmt));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_instr  = '0;
        #12;
        chk("rst_valid", 64'(v32), 64'd0);
        chk("rst_imm", imm64, 64'd0);
        chk("rst_fmt", 64'(fmt32), 64'd0);
        chk("rst_instr", 64'(ins32), 64'd0);
        chk("rst_dec", 64'(dec32), 64'd0);
        chk("rst_ill", 64'(ill32), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rdy_after_rst", 64'(r32), 64'd1);

        // directed decode vectors, free-flowing output
        send(32'hFFC12083, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 3'd1);
        chk("latency1", 64'(v32), 64'd1);
        send(32'hFE000CE3, 32'hFFFFFFF8, 64'hFFFFFFFF_FFFFFFF8, 3'd3);
        send(32'h0080006F, 32'h00000008, 64'h00000000_00000008, 3'd5);
        send(32'h123452B7, 32'h12345000, 64'h00000000_12345000, 3'd4);
        send(32'h800002B7, 32'h80000000, 64'hFFFFFFFF_80000000, 3'd4);
        send(32'h03F09093, 32'h0000001F, 64'h00000000_0000003F, 3'd6);
        send(32'hFE112E23, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 3'd2);
        send(32'h003100B3, 32'h00000000, 64'h00000000_00000000, 3'd0);
        send(32'h00500093, 32'h00000005, 64'h00000000_00000005, 3'd1);
        send(32'h40515093, 32'h00000005, 64'h00000000_00000005, 3'd6);
        send(32'h00000000, 32'h00000000, 64'h00000000_00000000, 3'd7);
        wait_drain();
        chk("dec_run1", 64'(dec32), 64'd11);
        chk("ill_run1", 64'(ill32), 64'd1);
        chk("decsat_run1", 64'(decs), 64'd3);
        chk("illsat_run1", 64'(ills), 64'd1);

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // backpressure: A main, B skid, C held
        out_ready = 1'b0;
        send(32'h00100093, 32'h00000001, 64'h1, 3'd1);
        chk("bp_rdyA", 64'(r32), 64'd1);
        send(32'hFE112E23, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 3'd2);
        chk("bp_rdyB", 64'(r32), 64'd0);
        fork
            send(32'h0080006F, 32'h00000008, 64'h8, 3'd5);
            begin
                tick();
                tick();
                chk("bp_hold_v", 64'(v32), 64'd1);
                chk("bp_hold_instr", 64'(ins32), 64'h00100093);
                chk("bp_hold_imm", 64'(imm32), 64'h1);
                chk("bp_hold_rdy", 64'(r32), 64'd0);
                out_ready = 1'b1;
            end
        join
        wait_drain();
        chk("bp_dec", 64'(dec32), 64'd3);
        chk("bp_decsat", 64'(decs), 64'd3);

        // flush with both entries full and a live input
        out_ready = 1'b0;
        send(32'h00700093, 32'h00000007, 64'h7, 3'd1);
        send(32'h00900093, 32'h00000009, 64'h9, 3'd1);
        in_valid  = 1'b1;
        in_instr  = 32'h00B00093;
        flush     = 1'b1;
        out_ready = 1'b1;
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        clear_q();
        chk("fl_valid", 64'(v32), 64'd0);
        chk("fl_rdy", 64'(r32), 64'd1);
        chk("fl_dec", 64'(dec32), 64'd3);
        chk("fl_data_kept", 64'(ins32), 64'h00700093);

        // flush dropping an input accepted in the flush cycle
        send(32'h00D00093, 32'h0000000D, 64'hD, 3'd1);
        in_valid = 1'b1;
        in_instr = 32'h00F00093;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        clear_q();
        chk("fl2_valid", 64'(v32), 64'd0);
        tick();
        tick();
        chk("fl2_dropped", 64'(v32), 64'd0);
        out_ready = 1'b1;
        send(32'h01100093, 32'h00000011, 64'h11, 3'd1);
        wait_drain();
        chk("fl2_dec", 64'(dec32), 64'd4);

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // illegal stream, 2-bit counters saturate at 3
        for (int k = 0; k < 5; k++) begin
            send(32'h0000007F, 32'h0, 64'h0, 3'd7);
        end
        wait_drain();
        chk("sat_dec", 64'(decs), 64'd3);
        chk("sat_ill", 64'(ills), 64'd3);
        chk("wide_dec", 64'(dec32), 64'd5);
        chk("wide_ill", 64'(ill32), 64'd5);

        // asynchronous reset between clock edges
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h0000007F;
        tick();
        in_valid  = 1'b0;
        chk("mid_pre_valid", 64'(vs), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_valid", 64'(vs), 64'd0);
        chk("mid_dec", 64'(decs), 64'd0);
        chk("mid_ill", 64'(ills), 64'd0);
        chk("mid_dec32", 64'(dec32), 64'd0);
        clear_q();
        tick();
        rst_n = 1'b1;
        tick();
        chk("end_q_empty", 64'(q32.size() + q64.size() + qs.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Parametrised, pipelined immediate-generation stage for the decode path. It accepts raw instructions over a valid/ready handshake and decodes every RV32I/RV64I immediate format (I, S, B, U, J, plus the shift-amount form). It returns a sign-extended XLEN-bit immediate and a format code one cycle later. A two-entry skid buffer provides full-throughput backpressure; a flush input and saturating statistics counters are included.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64 only.
CNT_W, 16, width of each statistics counter.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  discard all buffered entries this cycle
in_valid  in  1  instruction present
in_ready  out  1  stage can accept an instruction
in_instr  in  32  raw instruction word
out_valid  out  1  decoded result present
out_ready  in  1  consumer accepts the result
out_imm  out  XLEN  sign- or zero-extended immediate
out_fmt  out  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6=SHAMT, 7=ILLEGAL
out_instr  out  32  instruction word carried alongside the result
dec_cnt  out  CNT_W  count of output handshakes, saturating
ill_cnt  out  CNT_W  count of ILLEGAL output handshakes, saturating

Behaviour:
- Reset is asynchronous on rst_n low. It sets the following, all to 0:
  - out_valid, both entry-valid flags
  - out_imm, out_fmt, out_instr
  - dec_cnt, ill_cnt
- in_ready is 1 from the first cycle after reset, because the skid entry is empty.
- Decode uses opcode = in_instr[6:0]. Sign bit s = in_instr[31], replicated to XLEN.
  - LOAD 0000011, JALR 1100111, SYSTEM 1110011: I-format, imm = s-ext(instr[31:20]).
  - OP-IMM 0010011: I-format, except funct3 (instr[14:12]) = 001 or 101, which is SHAMT.
  - SHAMT: imm = zero-ext(instr[24:20]) when XLEN=32, zero-ext(instr[25:20]) when XLEN=64.
  - STORE 0100011: S-format, imm = s-ext({instr[31:25], instr[11:7]}).
  - BRANCH 1100011: B-format, imm = s-ext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - LUI 0110111, AUIPC 0010111: U-format, imm = s-ext({instr[31:12], 12'b0}). Upper bits are sign-filled when XLEN=64.
  - JAL 1101111: J-format, imm = s-ext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - OP 0110011: R-format, imm = 0.
  - Any other opcode, or instr[1:0] != 11: ILLEGAL, imm = 0.
- Pipeline: decode is combinational on the input; the result is registered.
  - Latency is exactly 1 cycle from the input handshake (in_valid and in_ready) to out_valid.
  - Throughput is 1 per cycle while out_ready=1.
- Storage: a main register drives the outputs, backed by one skid register.
  - in_ready is a registered signal equal to NOT skid_valid. It has no combinational path from out_ready.
  - Input accepted, main empty or draining this cycle: the entry goes to main.
  - Input accepted, main valid and not draining: the entry goes to skid.
  - Main drains (out_valid and out_ready) while skid is valid: skid moves to main, and the new input (if any) goes to skid.
  - Order is strictly FIFO; no entry is lost or duplicated.
- While out_valid=1 and out_ready=0, out_imm, out_fmt and out_instr hold stable.
- flush: on the next edge, main and skid are invalidated and any input handshaked in the flush cycle is dropped.
  - Counters ignore any output handshake that occurs in the flush cycle.
  - out_imm, out_fmt and out_instr data are not cleared; only the valid flags are.
- Counters:
  - dec_cnt increments on every output handshake.
  - ill_cnt increments on output handshakes with out_fmt=7.
  - Both saturate at 2^CNT_W-1 and never wrap.
- Reset asserted mid-operation clears all state immediately, regardless of clk.

Test Plan:
- LOAD: in_instr=0xFFC12083 (lw x1,-4(x2)), XLEN=32 -> next cycle out_valid=1, out_imm=0xFFFFFFFC, out_fmt=1.
- BRANCH and JAL:
  - 0xFE000CE3 (beq -8) -> out_imm=0xFFFFFFF8, out_fmt=3.
  - 0x0080006F (jal +8) -> out_imm=0x00000008, out_fmt=5.
- U-type and shift, XLEN=64:
  - 0x123452B7 -> out_imm=0x0000000012345000, out_fmt=4.
  - 0x800002B7 -> out_imm=0xFFFFFFFF80000000.
  - 0x03F09093 (slli shamt 63) -> out_imm=63, out_fmt=6.
- Backpressure: out_ready=0, present A, B, C back-to-back.
  - A lands in main, B in skid; in_ready=0 from the cycle after B is accepted; C is held.
  - Then raise out_ready -> A, B, C emerge on consecutive cycles in order; dec_cnt=3.
- Flush: with main and skid full and in_valid=1, pulse flush for one cycle.
  - Next cycle out_valid=0 and in_ready=1; the flushed entries never appear; dec_cnt is unchanged.
- Illegal and saturation: CNT_W=2, send 5 instructions of 0x0000007F with out_ready=1.
  - Each output has out_fmt=7 and out_imm=0.
  - ill_cnt and dec_cnt stop at 3.
  - Assert rst_n=0 mid-stream -> out_valid and the counters are 0 immediately.
